step_voice: RTL and testbench
=============================

# step_voice

Single gated square-wave voice that sits directly downstream of the loop shift register in the melody generator. On each step tick it samples one pattern bit, normally bit 0 of the rotating loop register. If the bit is 1, it plays a tone of programmable pitch for a programmable number of clocks. Its output drives the audio mixer/DAC pin, and it ends every note on a low half-cycle so the output never clicks.

## Interface
- DIV_WIDTH, 16, width of the half-period divider.
- HOLD_WIDTH, 16, width of the note-length counter.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- step_tick  in  1  one-cycle step strobe, asserted in the same cycle the loop register shifts.
- note_on  in  1  pattern bit, sampled only when step_tick=1.
- half_period  in  DIV_WIDTH  tone half-period in clk cycles; 0 means silent.
- hold_ticks  in  HOLD_WIDTH  gate length in clk cycles; 0 is treated as 1.
- gate  out  1  high while the note is held.
- audio_out  out  1  gated square wave.
- busy  out  1  high in PLAY or TAIL.

## Operation
- States:
  - IDLE: no note.
  - PLAY: gate held.
  - TAIL: gate released; waiting for the tone to reach low.
- Trigger is step_tick & note_on, in any state.
  - Loads the hold counter with max(hold_ticks,1).
  - Latches half_period into an internal register.
  - Clears the phase counter and sets tone=1.
  - Next state is PLAY.
- Retrigger in PLAY or TAIL applies the same load: the phase restarts high and hold restarts. No gap is inserted.
- step_tick with note_on=0 is ignored in every state. A playing note runs to completion.
- PLAY:
  - The hold counter decrements each cycle.
  - When it would reach 0, gate falls on the next cycle.
  - If tone=0 at that point, go to IDLE. Otherwise go to TAIL.
- TAIL:
  - The tone keeps running.
  - When the divider toggles tone to 0, go to IDLE in the same cycle.
- Divider:
  - The phase counter counts 0..latched_half_period-1.
  - At the terminal count it wraps to 0 and toggles tone.
  - It runs only in PLAY and TAIL.
- audio_out = tone & busy.
- If latched half_period=0:
  - The phase counter is frozen and tone is forced to 0, so audio_out stays 0.
  - Gate timing is unchanged, and PLAY exits directly to IDLE.
- Inputs half_period and hold_ticks are ignored except at a trigger.

## Timing
- Reset values: gate=0, audio_out=0, busy=0, state IDLE, all counters 0.
- rst mid-note returns all outputs to 0 on the next edge. rst has priority over a simultaneous trigger.
- All outputs are registered.
- Latency: trigger at cycle T makes gate, busy and audio_out high from T+1.
- gate is high for exactly max(hold_ticks,1) cycles: T+1 .. T+hold.
- Each half-cycle of audio_out lasts exactly half_period cycles.
- busy falls in the cycle after the final high→low transition of audio_out, or together with gate if the tone is already low.

## Structure
- Shared package `melody_pkg` contains:
  - The state enum: IDLE, PLAY, TAIL.
  - The default widths DIV_WIDTH and HOLD_WIDTH.
- One sub-module, `square_divider`, contains:
  - Inputs: enable, load, half_period.
  - Output: tone, plus a toggle-to-low strobe used by the TAIL exit.
- The FSM and hold counter stay in `step_voice`.

## Test plan
- Reset, then 10 idle cycles → gate=0, audio_out=0, busy=0 throughout.
- Single note: trigger at T with half_period=4, hold_ticks=16.
  - gate=1 for T+1..T+16.
  - audio_out high T+1..4, low T+5..8, high T+9..12, low T+13..16.
  - busy=0 at T+17 (no TAIL).
- TAIL case: half_period=4, hold_ticks=10.
  - gate=1 for T+1..T+10.
  - audio_out stays high through T+12 and is low at T+13.
  - busy falls at T+13.
- Retrigger: second trigger at T+6 during a note with hold=16.
  - audio_out high at T+7, restarting phase.
  - gate stays continuous through T+22.
- Silent and ignored steps:
  - half_period=0, hold_ticks=0 → gate high for 1 cycle, audio_out never high.
  - step_tick with note_on=0 mid-note → no change.
- rst asserted at T+5 of a playing note, in the same cycle as a trigger → all outputs 0 at T+6, state IDLE.

Source files
------------

// File: rtl/melody_pkg.sv
// Shared types and default widths for the melody generator voices.
package melody_pkg;

  // Default width of the tone half-period divider.
  localparam int DIV_WIDTH  = 16;
  // Default width of the note-length (gate) counter.
  localparam int HOLD_WIDTH = 16;

  // Voice state: no note, gate held, or gate released while the tone finishes.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    TAIL = 2'd2
  } voice_state_t;

endpackage : melody_pkg

// File: rtl/square_divider.sv
// Square-wave tone generator. The half-period is latched on load.
// A latched half-period of 0 freezes the phase and holds the tone low.
module square_divider #(
  parameter int DIV_WIDTH = melody_pkg::DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] half_period,
  output logic                 tone,
  output logic                 fall
);

  logic [DIV_WIDTH-1:0] half_q;
  logic [DIV_WIDTH-1:0] phase_q;
  logic                 silent;
  logic                 terminal;

  assign silent   = (half_q == '0);
  assign terminal = (phase_q == half_q - DIV_WIDTH'(1));

  // The tone is about to toggle from high to low on this edge.
  assign fall = enable && !silent && terminal && tone;

  // Phase counter and tone flop; a load restarts the phase with the tone high.
  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      half_q  <= '0;
      phase_q <= '0;
      tone    <= 1'b0;
    end else if (load) begin
      half_q  <= half_period;
      phase_q <= '0;
      tone    <= (half_period != '0);
    end else if (silent) begin
      tone    <= 1'b0;
    end else if (enable) begin
      if (terminal) begin
        phase_q <= '0;
        tone    <= ~tone;
      end else begin
        phase_q <= phase_q + DIV_WIDTH'(1);
      end
    end
  end

endmodule : square_divider

// File: rtl/step_voice.sv
// Single gated square-wave voice triggered by the loop shift register.
// Each note ends on a low half-cycle so the output never clicks.
module step_voice #(
  parameter int DIV_WIDTH  = melody_pkg::DIV_WIDTH,
  parameter int HOLD_WIDTH = melody_pkg::HOLD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step_tick,
  input  logic                  note_on,
  input  logic [DIV_WIDTH-1:0]  half_period,
  input  logic [HOLD_WIDTH-1:0] hold_ticks,
  output logic                  gate,
  output logic                  audio_out,
  output logic                  busy
);

  import melody_pkg::*;

  voice_state_t          state_q, state_d;
  logic [HOLD_WIDTH-1:0] hold_q, hold_d;
  logic                  trigger;
  logic                  tone;
  logic                  fall;

  assign trigger = step_tick & note_on;

  square_divider #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .enable     (state_q != IDLE),
    .load       (trigger),
    .half_period(half_period),
    .tone       (tone),
    .fall       (fall)
  );

  // Next-state and hold-counter logic; a trigger overrides everything else.
  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      PLAY: begin
        hold_d = hold_q - HOLD_WIDTH'(1);
        if (hold_q <= HOLD_WIDTH'(1)) begin
          // Tone already low, or dropping low on this very edge: no tail needed.
          state_d = (!tone || fall) ? IDLE : TAIL;
        end
      end
      TAIL: begin
        if (fall) state_d = IDLE;
      end
      default: state_d = state_q;
    endcase
    if (trigger) begin
      state_d = PLAY;
      hold_d  = (hold_ticks == '0) ? HOLD_WIDTH'(1) : hold_ticks;
    end
  end

  // State and hold counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign gate      = (state_q == PLAY);
  assign busy      = (state_q != IDLE);
  assign audio_out = tone & busy;

endmodule : step_voice

// File: tb/tb_step_voice.sv
// Directed scoreboard bench for step_voice: each trigger pushes the expected
// per-cycle {gate, audio_out, busy} sequence, and every cycle pops and compares.
module tb_step_voice;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step_tick = 1'b0;
  logic        note_on = 1'b0;
  logic [15:0] half_period = '0;
  logic [15:0] hold_ticks = '0;
  logic        gate, audio_out, busy;

  typedef struct {
    logic [2:0] v;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  step_voice dut (
    .clk        (clk),
    .rst        (rst),
    .step_tick  (step_tick),
    .note_on    (note_on),
    .half_period(half_period),
    .hold_ticks (hold_ticks),
    .gate       (gate),
    .audio_out  (audio_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic push(input logic g, input logic a, input logic b, input string tag);
    exp_t e;
    e.v   = {g, a, b};
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Expected note body: k counts cycles after the trigger, tone toggles every hp cycles.
  task automatic push_note(input int first_k, input int last_k, input int hp, input string tag);
    for (int k = first_k; k <= last_k; k++)
      push(1'b1, (((k - 1) / hp) % 2) == 0, 1'b1, $sformatf("%s_k%0d", tag, k));
  endtask

  // Advance one cycle: inputs are one-shot, outputs are checked at the falling edge.
  task automatic cyc(input int n);
    exp_t       e;
    logic [2:0] obs;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      step_tick = 1'b0;
      note_on   = 1'b0;
      rst       = 1'b0;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        obs = {gate, audio_out, busy};
        total++;
        assert (obs === e.v) else begin
          bad++;
          $error("FAIL %s: {gate,audio,busy} observed=%b expected=%b", e.tag, obs, e.v);
        end
      end
    end
  endtask

  task automatic trig(input logic [15:0] hp, input logic [15:0] ht);
    step_tick   = 1'b1;
    note_on     = 1'b1;
    half_period = hp;
    hold_ticks  = ht;
  endtask

  initial begin
    // Reset and idle.
    for (int k = 0; k < 12; k++) push(1'b0, 1'b0, 1'b0, $sformatf("reset_idle_%0d", k));
    cyc(12);

    // Single note, hold ends on a low half-cycle: no tail.
    trig(16'd4, 16'd16);
    push_note(1, 16, 4, "single");
    push(1'b0, 1'b0, 1'b0, "single_end");
    cyc(17);
    push(1'b0, 1'b0, 1'b0, "single_gap");
    cyc(1);

    // Hold ends while the tone is high: tail through T+12.
    trig(16'd4, 16'd10);
    push_note(1, 10, 4, "tail");
    push(1'b0, 1'b1, 1'b1, "tail_k11");
    push(1'b0, 1'b1, 1'b1, "tail_k12");
    push(1'b0, 1'b0, 1'b0, "tail_k13");
    cyc(13);
    push(1'b0, 1'b0, 1'b0, "tail_gap");
    cyc(1);

    // Retrigger at T+6 with an ignored step at T+10.
    trig(16'd4, 16'd16);
    push_note(1, 6, 4, "retrig_a");
    cyc(6);
    trig(16'd4, 16'd16);
    push_note(1, 16, 4, "retrig_b");
    push(1'b0, 1'b0, 1'b0, "retrig_end");
    cyc(4);
    step_tick   = 1'b1;
    note_on     = 1'b0;
    half_period = 16'd2;
    hold_ticks  = 16'd3;
    cyc(13);
    push(1'b0, 1'b0, 1'b0, "retrig_gap");
    cyc(1);

    // Silent note with zero hold: one gate cycle, no audio.
    trig(16'd0, 16'd0);
    push(1'b1, 1'b0, 1'b1, "silent_k1");
    push(1'b0, 1'b0, 1'b0, "silent_k2");
    push(1'b0, 1'b0, 1'b0, "silent_k3");
    cyc(3);

    // Reset at T+5 coinciding with a trigger: reset wins.
    trig(16'd4, 16'd16);
    push_note(1, 5, 4, "rst_mid");
    cyc(5);
    trig(16'd4, 16'd16);
    rst = 1'b1;
    for (int k = 6; k < 10; k++) push(1'b0, 1'b0, 1'b0, $sformatf("rst_mid_k%0d", k));
    cyc(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_step_voice
